// File: rtl/uart_status_msg_gen.sv
// ASCII status-line generator: "current state:<mode> rate:<digits>" + line end over valid/ready.
// Optional macro UART_MSG_CRLF_EN inserts 0x0D before the final 0x0A.
module uart_status_msg_gen #(
  parameter int unsigned RATE_W  = 8,
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned FIELD_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [RATE_W-1:0] i_rate,
  input  logic              i_abort,
  output logic [7:0]        o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);

`ifdef UART_MSG_CRLF_EN
  localparam int unsigned L = 21 + FIELD_W + DIGITS;
`else
  localparam int unsigned L = 20 + FIELD_W + DIGITS;
`endif
  localparam int unsigned IW   = $clog2(L);
  localparam int unsigned CW   = $clog2(RATE_W + 1);
  localparam int unsigned MAXV = 10**DIGITS - 1;
  localparam int unsigned DSTART = 19 + FIELD_W;

  localparam logic [8*14-1:0] PFX  = "current state:";
  localparam logic [8*5-1:0]  RLBL = "rate:";

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d, idx_n;
  logic [1:0]        mode_q, mode_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] sh_q, sh_d;
  logic [19:0]       bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sat;

  function automatic logic [7:0] line_byte(input int unsigned i, input logic [1:0] mode,
                                           input logic [19:0] bcd, input logic s);
    logic [8*12-1:0] name;
    int unsigned     p;
    logic [3:0]      nib;
    line_byte = 8'h20;
    name      = "initial     ";
    case (mode)
      2'd0:    name = "initial     ";
      2'd1:    name = "normal      ";
      2'd2:    name = "rate control";
      default: name = "finish      ";
    endcase
    if (i < 14) begin
      line_byte = PFX[8*(13-i) +: 8];
    end else if (i < 14 + FIELD_W) begin
      p = i - 14;
      if (p < 12) line_byte = name[8*(11-p) +: 8];
    end else if (i < DSTART) begin
      line_byte = RLBL[8*(DSTART-1-i) +: 8];
    end else if (i < DSTART + DIGITS) begin
      p   = i - DSTART;
      nib = bcd[4*(DIGITS-1-p) +: 4];
      line_byte = s ? 8'h39 : {4'h3, nib};
    end else if (i == L - 1) begin
      line_byte = 8'h0A;
    end else begin
      line_byte = 8'h0D;
    end
  endfunction

  // Shift/add-3 step: correct each BCD nibble, then shift the next rate bit in.
  function automatic logic [19:0] dabble(input logic [19:0] b, input logic in_bit);
    logic [19:0] t;
    t = b;
    for (int unsigned k = 0; k < 5; k++) begin
      if (t[4*k +: 4] >= 4'd5) t[4*k +: 4] = t[4*k +: 4] + 4'd3;
    end
    return {t[18:0], in_bit};
  endfunction

  assign sat   = 32'(rate_q) > MAXV;
  assign idx_n = idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    rate_d  = rate_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (cnt_q != '0) begin
      bcd_d = dabble(bcd_q, sh_q[RATE_W-1]);
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - CW'(1);
    end

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        data_d  = '1;
        if (i_start && !i_abort) begin
          state_d = SEND;
          mode_d  = i_mode;
          rate_d  = i_rate;
          sh_d    = i_rate;
          bcd_d   = '0;
          cnt_d   = CW'(RATE_W);
          idx_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          data_d  = line_byte(32'd0, i_mode, '0, 1'b0);
        end
      end
      SEND: begin
        // The next byte is fetched one cycle ahead so o_data stays a pure register.
        if (i_abort || (valid_q && i_ready && idx_q == IW'(L - 1))) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          data_d  = '1;
          done_d  = !i_abort;
        end else if (valid_q && i_ready) begin
          idx_d  = idx_n;
          data_d = line_byte(32'(idx_n), mode_q, bcd_q, sat);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= '0;
      rate_q  <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      rate_q  <= rate_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_status_msg_gen.sv
// Directed bench for uart_status_msg_gen: default, DIGITS=2 and RATE_W=16/DIGITS=5 instances.
module tb_uart_status_msg_gen;

  logic        clk = 1'b0;
  logic        reset, start_v, abort, ready;
  logic [1:0]  mode;
  logic [15:0] rate16;
  int          sel;

  logic [7:0] d0, d2, d3;
  logic       v0, v2, v3, b0, b2, b3, dn0, dn2, dn3;
  logic [7:0] m_data;
  logic       m_valid, m_busy, m_done;

  int checks = 0;
  int errors = 0;
  int stall_err;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  int         obs_t_done;
  logic       obs_first_valid, obs_done_valid, obs_done_busy;
  logic [7:0] obs_first_data, obs_done_data;

  always #5 clk = ~clk;

  uart_status_msg_gen #(.RATE_W(8), .DIGITS(3), .FIELD_W(12)) dut0 (
    .clk(clk), .reset(reset), .i_start(start_v && sel == 0), .i_mode(mode),
    .i_rate(rate16[7:0]), .i_abort(abort), .o_data(d0), .o_valid(v0),
    .i_ready(ready), .o_busy(b0), .o_done(dn0));

  uart_status_msg_gen #(.RATE_W(8), .DIGITS(2), .FIELD_W(12)) dut2 (
    .clk(clk), .reset(reset), .i_start(start_v && sel == 2), .i_mode(mode),
    .i_rate(rate16[7:0]), .i_abort(abort), .o_data(d2), .o_valid(v2),
    .i_ready(ready), .o_busy(b2), .o_done(dn2));

  uart_status_msg_gen #(.RATE_W(16), .DIGITS(5), .FIELD_W(12)) dut3 (
    .clk(clk), .reset(reset), .i_start(start_v && sel == 3), .i_mode(mode),
    .i_rate(rate16), .i_abort(abort), .o_data(d3), .o_valid(v3),
    .i_ready(ready), .o_busy(b3), .o_done(dn3));

  always_comb begin
    case (sel)
      2:       begin m_data = d2; m_valid = v2; m_busy = b2; m_done = dn2; end
      3:       begin m_data = d3; m_valid = v3; m_busy = b3; m_done = dn3; end
      default: begin m_data = d0; m_valid = v0; m_busy = b0; m_done = dn0; end
    endcase
  end

  function automatic void build_exp(input logic [1:0] m, input int unsigned r, input int nd);
    string pfx, nm, rl;
    int unsigned p10, pw;
    pfx = "current state:";
    rl  = "rate:";
    case (m)
      2'd0:    nm = "initial";
      2'd1:    nm = "normal";
      2'd2:    nm = "rate control";
      default: nm = "finish";
    endcase
    exp_q.delete();
    for (int i = 0; i < pfx.len(); i++) exp_q.push_back(pfx[i]);
    for (int i = 0; i < 12; i++) exp_q.push_back(i < nm.len() ? nm[i] : 8'h20);
    for (int i = 0; i < rl.len(); i++) exp_q.push_back(rl[i]);
    p10 = 1;
    for (int i = 0; i < nd; i++) p10 = p10 * 10;
    for (int k = nd - 1; k >= 0; k--) begin
      pw = 1;
      for (int j = 0; j < k; j++) pw = pw * 10;
      exp_q.push_back(r > p10 - 1 ? 8'h39 : 8'(48 + (r / pw) % 10));
    end
`ifdef UART_MSG_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
  endfunction

  function automatic int line_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic start_line(input logic [1:0] m, input logic [15:0] r);
    @(negedge clk);
    mode = m; rate16 = r; start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
  endtask

  // Collects one line starting at the first cycle after start acceptance.
  task automatic recv_line(input bit rnd, input bit disturb, input bit b2b,
                           input logic [1:0] nm, input logic [15:0] nr);
    logic       prev_stall;
    logic [7:0] prev_data;
    got_q.delete();
    obs_t_done = -1;
    obs_first_valid = m_valid;
    obs_first_data  = m_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    ready = 1'b1;
    for (int t = 1; t <= 600; t++) begin
      if (t > 1) @(negedge clk);
      if (disturb) begin
        if (t == 5) begin start_v = 1'b1; mode = 2'd0; rate16 = 16'd200; end
        else start_v = 1'b0;
      end
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_err++;
      if (m_done === 1'b1) begin
        obs_t_done = t;
        obs_done_valid = m_valid;
        obs_done_busy  = m_busy;
        obs_done_data  = m_data;
        if (b2b) begin start_v = 1'b1; mode = nm; rate16 = nr; end
        break;
      end
      if (m_valid !== 1'b1) break;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ready) got_q.push_back(m_data);
      prev_stall = !ready;
      prev_data  = m_data;
    end
    ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_v = 1'b0; abort = 1'b0; ready = 1'b0;
    mode = '0; rate16 = '0; sel = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    checks++;
    if (m_data !== 8'hFF) begin errors++; $display("FAIL reset_data: got 0x%02h expected 0xff", m_data); end
    checks++;
    if (m_busy !== 1'b0 || m_done !== 1'b0) begin
      errors++; $display("FAIL reset_busy_done: got busy=%b done=%b expected 0/0", m_busy, m_done);
    end
    checks++;
    if (d2 !== 8'hFF || d3 !== 8'hFF || v2 !== 1'b0 || v3 !== 1'b0) begin
      errors++; $display("FAIL reset_other: got d2=0x%02h d3=0x%02h v2=%b v3=%b expected ff/ff/0/0", d2, d3, v2, v3);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int d;
    sel = 0;
    build_exp(2'd1, 25, 3);
    start_line(2'd1, 16'd25);
    recv_line(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    checks++;
    if (obs_first_valid !== 1'b1 || obs_first_data !== 8'h63) begin
      errors++; $display("FAIL basic_first: got valid=%b data=0x%02h expected 1/0x63", obs_first_valid, obs_first_data);
    end
    checks++;
    if (obs_t_done !== exp_q.size() + 1) begin
      errors++; $display("FAIL basic_done_cycle: got %0d expected %0d", obs_t_done, exp_q.size() + 1);
    end
    checks++;
    if (obs_done_valid !== 1'b0 || obs_done_busy !== 1'b0 || obs_done_data !== 8'hFF) begin
      errors++; $display("FAIL basic_done_outputs: got valid=%b busy=%b data=0x%02h expected 0/0/0xff",
                         obs_done_valid, obs_done_busy, obs_done_data);
    end
    checks++;
    d = line_diff();
    if (d != -1) begin
      errors++; $display("FAIL basic_line: byte %0d got 0x%02h expected 0x%02h (%0d of %0d bytes)",
                         d, got_q[d], exp_q[d], got_q.size(), exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (m_data !== 8'hFF || m_done !== 1'b0) begin
      errors++; $display("FAIL basic_after: got data=0x%02h done=%b expected 0xff/0", m_data, m_done);
    end
  endtask

  task automatic test_backpressure();
    int d;
    sel = 0;
    stall_err = 0;
    build_exp(2'd2, 7, 3);
    start_line(2'd2, 16'd7);
    recv_line(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
    checks++;
    if (obs_t_done < 0) begin errors++; $display("FAIL bp_done: got no o_done expected a pulse"); end
    checks++;
    d = line_diff();
    if (d != -1) begin
      errors++; $display("FAIL bp_line: byte %0d got 0x%02h expected 0x%02h (%0d of %0d bytes)",
                         d, got_q[d], exp_q[d], got_q.size(), exp_q.size());
    end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err); end
  endtask

  task automatic test_saturation();
    int          d;
    int          t_sel[4]  = '{2, 2, 3, 3};
    int          t_dig[4]  = '{2, 2, 5, 5};
    logic [15:0] t_rate[4] = '{16'd255, 16'd42, 16'd65535, 16'd9};
    for (int i = 0; i < 4; i++) begin
      sel = t_sel[i];
      build_exp(2'(i), t_rate[i], t_dig[i]);
      start_line(2'(i), t_rate[i]);
      recv_line(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      checks++;
      d = line_diff();
      if (d != -1 || obs_t_done < 0) begin
        errors++; $display("FAIL digits_%0d: byte %0d got 0x%02h expected 0x%02h (%0d of %0d bytes, done at %0d)",
                           i, d, got_q[d], exp_q[d], got_q.size(), exp_q.size(), obs_t_done);
      end
    end
    sel = 0;
  endtask

  task automatic test_abort();
    int   n, d;
    logic done_seen;
    sel = 0;
    build_exp(2'd0, 3, 3);
    start_line(2'd0, 16'd3);
    got_q.delete();
    n = 0;
    ready = 1'b1;
    for (int t = 0; t < 100 && n < 11; t++) begin
      if (t > 0) @(negedge clk);
      if (m_valid === 1'b1) begin
        if (n == 10) abort = 1'b1;
        got_q.push_back(m_data);
        n++;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'hFF || m_busy !== 1'b0 || m_done !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: got valid=%b data=0x%02h busy=%b done=%b expected 0/0xff/0/0",
                         m_valid, m_data, m_busy, m_done);
    end
    done_seen = 1'b0;
    repeat (3) begin @(negedge clk); if (m_done === 1'b1 || m_valid === 1'b1) done_seen = 1'b1; end
    checks++;
    if (done_seen !== 1'b0) begin errors++; $display("FAIL abort_quiet: got activity after abort expected none"); end
    while (exp_q.size() > 11) void'(exp_q.pop_back());
    checks++;
    d = line_diff();
    if (d != -1) begin
      errors++; $display("FAIL abort_prefix: byte %0d got 0x%02h expected 0x%02h (%0d bytes)", d, got_q[d], exp_q[d], got_q.size());
    end
    build_exp(2'd3, 123, 3);
    start_line(2'd3, 16'd123);
    recv_line(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    checks++;
    d = line_diff();
    if (d != -1 || obs_t_done !== exp_q.size() + 1) begin
      errors++; $display("FAIL abort_restart: byte %0d got 0x%02h expected 0x%02h, done at %0d expected %0d",
                         d, got_q[d], exp_q[d], obs_t_done, exp_q.size() + 1);
    end
  endtask

  task automatic test_restart_ignored();
    int   d;
    logic extra;
    sel = 0;
    build_exp(2'd3, 100, 3);
    start_line(2'd3, 16'd100);
    recv_line(1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
    checks++;
    d = line_diff();
    if (d != -1 || obs_t_done !== exp_q.size() + 1) begin
      errors++; $display("FAIL restart_line: byte %0d got 0x%02h expected 0x%02h, done at %0d expected %0d",
                         d, got_q[d], exp_q[d], obs_t_done, exp_q.size() + 1);
    end
    extra = 1'b0;
    repeat (3) begin @(negedge clk); if (m_valid !== 1'b0 || m_busy !== 1'b0) extra = 1'b1; end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL restart_queued: got a second line expected idle"); end
  endtask

  task automatic test_back_to_back();
    int d;
    sel = 0;
    build_exp(2'd1, 250, 3);
    start_line(2'd1, 16'd250);
    recv_line(1'b0, 1'b0, 1'b1, 2'd2, 16'd1);
    checks++;
    d = line_diff();
    if (d != -1) begin
      errors++; $display("FAIL b2b_first_line: byte %0d got 0x%02h expected 0x%02h", d, got_q[d], exp_q[d]);
    end
    @(negedge clk);
    start_v = 1'b0;
    build_exp(2'd2, 1, 3);
    recv_line(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    checks++;
    if (obs_first_valid !== 1'b1 || obs_first_data !== 8'h63) begin
      errors++; $display("FAIL b2b_first_byte: got valid=%b data=0x%02h expected 1/0x63", obs_first_valid, obs_first_data);
    end
    checks++;
    d = line_diff();
    if (d != -1 || obs_t_done !== exp_q.size() + 1) begin
      errors++; $display("FAIL b2b_second_line: byte %0d got 0x%02h expected 0x%02h, done at %0d",
                         d, got_q[d], exp_q[d], obs_t_done);
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    ready = 1'b1;
    start_line(2'd0, 16'd50);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'hFF || m_busy !== 1'b0 || m_done !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got valid=%b data=0x%02h busy=%b done=%b expected 0/0xff/0/0",
                         m_valid, m_data, m_busy, m_done);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_abort();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
